capture_ram_bank: RTL and testbench
===================================

CAPTURE_RAM_BANK -- requirements
Module: capture_ram_bank

Interface
REQ-001 Parameter DATA_W, 16, sample and data_bus width.
REQ-002 Parameter ADDR_W, 10, log2 of per-channel depth (DEPTH = 2**ADDR_W).
REQ-003 Parameter NUM_CH, 4, hydrophone channel count, power of two, 1..8.
REQ-004 Parameter BANK_BIT, 3, index of the active-low bank_select bit that selects this block.
REQ-005 Parameter PRE_LEN, 256, and POST_LEN, 512; the block SHALL require PRE_LEN+POST_LEN <= DEPTH.
REQ-006 Clocking SHALL be one clock, clk; reset SHALL be asynchronous and active-low, rst_n.
REQ-007 clk  in  1  system clock; all logic rising-edge.
REQ-008 rst_n  in  1  async active-low reset.
REQ-009 sample_in  in  NUM_CH*DATA_W  one sample per channel, channel 0 in LSBs.
REQ-010 sample_valid  in  1  one-cycle strobe qualifying sample_in.
REQ-011 trigger  in  1  ping-detect pulse from detector logic.
REQ-012 addr  in  19  DSP EMIF address; addr[18] 0 = sample space, 1 = register space.
REQ-013 data_bus  inout  DATA_W  EMIF data, tri-stated unless driving a read.
REQ-014 bank_select  in  4  EMIF chip selects, active low.
REQ-015 are / awe  in  1 each  EMIF read / write strobes, active low.
REQ-016 ardy  out(tri)  1  EMIF ready; Z when not selected.
REQ-017 done  out  1  capture-complete flag for DSP interrupt.

Function
REQ-018 sel SHALL be ~bank_select[BANK_BIT]; data_bus SHALL be driven only when sel && ~are, else Z.
REQ-019 FSM states IDLE, PRE, ARMED, POST, DONE; every sample_valid in PRE/ARMED/POST SHALL write all NUM_CH words at wr_ptr, then wr_ptr <= wr_ptr+1 mod DEPTH.
REQ-020 Arm (write bit0=1 to reg 0) SHALL move any state to PRE, clear pre_cnt, post_cnt, done, early; arm beats a same-cycle trigger.
REQ-021 PRE -> ARMED once pre_cnt reaches PRE_LEN; trigger in PRE SHALL be ignored and set status bit early.
REQ-022 ARMED -> POST on trigger or force (reg 0 bit1); trig_ptr SHALL latch wr_ptr of that cycle, including a same-cycle sample write.
REQ-023 POST -> DONE after POST_LEN further samples; done SHALL rise the cycle after the last write and hold until arm or reset.
REQ-024 Triggers in IDLE, POST, DONE SHALL be ignored; no RAM writes in IDLE or DONE.
REQ-025 Sample read: addr[ADDR_W+log2(NUM_CH)-1:ADDR_W] = channel, addr[ADDR_W-1:0] = logical index i; physical row = (trig_ptr - PRE_LEN + i) mod DEPTH.
REQ-026 Register read map: 0 control (reads 0), 1 status {early, state[2:0]}, 2 trig_ptr, 3 wr_ptr, zero-extended.
REQ-027 Read handshake: falling are while sel SHALL drive ardy 0; address registered cycle 1, RAM data registered cycle 2, ardy 1 from cycle 3 until are rises.
REQ-028 ardy SHALL be 1 (not Z) when sel && are high; Z when ~sel.
REQ-029 Register write SHALL occur once per awe falling edge while sel; sample-space writes SHALL be ignored.
REQ-030 Reads SHALL be permitted in every state; DONE guarantees window stability.

Reset
REQ-031 On rst_n low: state IDLE, wr_ptr, trig_ptr, counters, early, done = 0; ardy, data_bus Z; strobe edge detectors = inactive (high).
REQ-032 Reset mid-capture or mid-read SHALL abort; RAM contents need not be cleared.

Structure
REQ-033 Shared package capture_pkg SHALL hold the state enum, register offsets, control/status bit positions.
REQ-034 Storage SHALL be one sub-module sdp_ram: simple dual-port, NUM_CH*DEPTH x DATA_W, write port A, 1-cycle registered read port B.

Verification (DATA_W=16, ADDR_W=6, NUM_CH=2, PRE_LEN=8, POST_LEN=16)
REQ-035 Arm, ramp ch0=n, ch1=0x100+n, trigger at n=20 -> done after n=35; read ch0 i=0..23 -> 12..35.
REQ-036 Trigger at n=3 after arm -> ignored, status early=1, state PRE; later trigger at n=30 captures 22..45.
REQ-037 Run 100 samples before trigger (wrap) -> trig_ptr=36, ch1 i=0 reads 0x15C, i=23 reads 0x173.
REQ-038 Read with are low 4 cycles -> ardy 0 for cycles 0-2, 1 at cycle 3, data_bus Z when bank_select[3]=1.
REQ-039 Arm write and trigger same cycle in ARMED -> state PRE, trig_ptr unchanged, done 0.
REQ-040 rst_n low during POST -> state IDLE, done 0, ardy Z immediately, no further RAM writes.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared definitions for the sonar capture RAM bank: FSM states, EMIF register map
// and control/status bit positions.
package capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int EMIF_ADDR_W = 19;
  localparam int SPACE_BIT   = 18;
  localparam int REG_OFF_W   = 2;

  localparam logic [REG_OFF_W-1:0] REG_CTRL   = 2'd0;
  localparam logic [REG_OFF_W-1:0] REG_STATUS = 2'd1;
  localparam logic [REG_OFF_W-1:0] REG_TRIG   = 2'd2;
  localparam logic [REG_OFF_W-1:0] REG_WRPTR  = 2'd3;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_FORCE_BIT = 1;
  localparam int STAT_EARLY_BIT = 3;

  function automatic logic [3:0] status_word(input logic early, input state_e st);
    logic [3:0] w;
    w = 4'b0000;
    w[2:0] = st;
    w[STAT_EARLY_BIT] = early;
    return w;
  endfunction

endpackage

// File: rtl/capture_ram_bank_if.sv
// EMIF control signals seen by the capture bank; the tri-stated data_bus and
// ardy stay on the top-level ports.
interface capture_ram_bank_if;
  import capture_pkg::*;

  logic [EMIF_ADDR_W-1:0] addr;
  logic [3:0]             bank_select;
  logic                   are;
  logic                   awe;

  modport master (output addr, bank_select, are, awe);
  modport slave  (input  addr, bank_select, are, awe);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port sample store: one bank per channel, all channels written in the
// same cycle on port A, one word read on port B with a registered output.
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2
) (
  input  logic                     clk,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic [NUM_CH*DATA_W-1:0] wdata_a,
  input  logic [ADDR_W-1:0]        addr_b,
  input  logic [CH_W-1:0]          ch_b,
  output logic [DATA_W-1:0]        rdata_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] bank_rd_s [NUM_CH];
  logic [CH_W-1:0]   ch_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Per-channel storage with registered read
    always_ff @(posedge clk) begin
      if (we_a) begin
        mem[addr_a] <= wdata_a[g*DATA_W +: DATA_W];
      end
      rd_q <= mem[addr_b];
    end

    assign bank_rd_s[g] = rd_q;
  end

  // Channel select follows the read address by one cycle
  always_ff @(posedge clk) begin
    ch_q <= ch_b;
  end

  assign rdata_b = bank_rd_s[ch_q];

endmodule

// File: rtl/capture_ram_bank.sv
// Hydrophone capture bank: pre/post-trigger ring-buffer capture of NUM_CH channels,
// read back by a DSP over an asynchronous-style EMIF with a tri-stated ready.
module capture_ram_bank
  import capture_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 10,
  parameter int NUM_CH   = 4,
  parameter int BANK_BIT = 3,
  parameter int PRE_LEN  = 256,
  parameter int POST_LEN = 512
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] sample_in,
  input  logic                     sample_valid,
  input  logic                     trigger,
  capture_ram_bank_if.slave        emif,
  inout  wire  [DATA_W-1:0]        data_bus,
  output wire                      ardy,
  output logic                     done
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d;
  logic [CNT_W-1:0]       pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
  logic                   early_q, early_d, done_q, done_d;
  logic                   are_q, awe_q, ardy_q, ardy_d;
  logic [1:0]             rd_phase_q, rd_phase_d;
  logic [EMIF_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d, reg_rdata_s, ram_rdata_s;

  logic sel_s, are_fall_s, reg_wr_s, arm_s, force_s, wr_en_s;
  logic [CNT_W-1:0]  pre_inc_s, post_inc_s, post_first_s;
  logic [ADDR_W-1:0] rd_row_s;
  logic [CH_W-1:0]   rd_ch_s;
  logic              emif_unused_s;

  assign sel_s      = ~emif.bank_select[BANK_BIT];
  assign are_fall_s = are_q & ~emif.are;
  assign reg_wr_s   = awe_q & ~emif.awe & sel_s & emif.addr[SPACE_BIT]
                    & (emif.addr[REG_OFF_W-1:0] == REG_CTRL);
  assign arm_s      = reg_wr_s & data_bus[CTRL_ARM_BIT];
  assign force_s    = reg_wr_s & data_bus[CTRL_FORCE_BIT];
  assign wr_en_s    = sample_valid & (state_q inside {ST_PRE, ST_ARMED, ST_POST});
  assign pre_inc_s  = pre_cnt_q + CNT_ONE;
  assign post_inc_s = post_cnt_q + CNT_ONE;
  // The sample written in the trigger cycle is the first post-trigger sample
  assign post_first_s = wr_en_s ? CNT_ONE : {CNT_W{1'b0}};

  // Capture FSM next state; arm overrides anything else happening that cycle
  always_comb begin
    state_d    = state_q;
    trig_ptr_d = trig_ptr_q;
    pre_cnt_d  = pre_cnt_q;
    post_cnt_d = post_cnt_q;
    early_d    = early_q;
    done_d     = done_q;
    wr_ptr_d   = wr_en_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    if (arm_s) begin
      state_d    = ST_PRE;
      pre_cnt_d  = {CNT_W{1'b0}};
      post_cnt_d = {CNT_W{1'b0}};
      early_d    = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: state_d = state_q;
        ST_PRE: begin
          early_d = early_q | trigger;
          if (wr_en_s) begin
            pre_cnt_d = pre_inc_s;
            state_d   = (pre_inc_s == CNT_W'(PRE_LEN)) ? ST_ARMED : ST_PRE;
          end else begin
            pre_cnt_d = pre_cnt_q;
          end
        end
        ST_ARMED: begin
          if (trigger || force_s) begin
            trig_ptr_d = wr_ptr_q;
            post_cnt_d = post_first_s;
            state_d    = (post_first_s == CNT_W'(POST_LEN)) ? ST_DONE : ST_POST;
            done_d     = (post_first_s == CNT_W'(POST_LEN));
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_POST: begin
          if (wr_en_s) begin
            post_cnt_d = post_inc_s;
            state_d    = (post_inc_s == CNT_W'(POST_LEN)) ? ST_DONE : ST_POST;
            done_d     = (post_inc_s == CNT_W'(POST_LEN));
          end else begin
            post_cnt_d = post_cnt_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Capture state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wr_ptr_q   <= {ADDR_W{1'b0}};
      trig_ptr_q <= {ADDR_W{1'b0}};
      pre_cnt_q  <= {CNT_W{1'b0}};
      post_cnt_q <= {CNT_W{1'b0}};
      early_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      trig_ptr_q <= trig_ptr_d;
      pre_cnt_q  <= pre_cnt_d;
      post_cnt_q <= post_cnt_d;
      early_q    <= early_d;
      done_q     <= done_d;
    end
  end

  assign done     = done_q;
  assign rd_ch_s  = rd_addr_q[ADDR_W +: CH_W];
  assign rd_row_s = trig_ptr_q - ADDR_W'(PRE_LEN) + rd_addr_q[ADDR_W-1:0];

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_ram (
    .clk     (clk),
    .we_a    (wr_en_s),
    .addr_a  (wr_ptr_q),
    .wdata_a (sample_in),
    .addr_b  (rd_row_s),
    .ch_b    (rd_ch_s),
    .rdata_b (ram_rdata_s)
  );

  // Register-space read mux
  always_comb begin
    case (rd_addr_q[REG_OFF_W-1:0])
      REG_STATUS: reg_rdata_s = DATA_W'(status_word(early_q, state_q));
      REG_TRIG:   reg_rdata_s = DATA_W'(trig_ptr_q);
      REG_WRPTR:  reg_rdata_s = DATA_W'(wr_ptr_q);
      default:    reg_rdata_s = {DATA_W{1'b0}};
    endcase
  end

  // Read handshake: phase 1 address held, phase 2 RAM output valid, phase 3 data latched
  always_comb begin
    rd_phase_d = rd_phase_q;
    ardy_d     = ardy_q;
    rd_addr_d  = rd_addr_q;
    rdata_d    = rdata_q;
    if (emif.are) begin
      ardy_d     = 1'b1;
      rd_phase_d = 2'd0;
    end else if (are_fall_s && sel_s) begin
      ardy_d     = 1'b0;
      rd_phase_d = 2'd1;
      rd_addr_d  = emif.addr;
    end else begin
      case (rd_phase_q)
        2'd1: rd_phase_d = 2'd2;
        2'd2: begin
          rd_phase_d = 2'd3;
          rdata_d    = rd_addr_q[SPACE_BIT] ? reg_rdata_s : ram_rdata_s;
        end
        2'd3: begin
          rd_phase_d = 2'd0;
          ardy_d     = 1'b1;
        end
        default: rd_phase_d = rd_phase_q;
      endcase
    end
  end

  // EMIF strobe edge detectors and read-path registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      are_q      <= 1'b1;
      awe_q      <= 1'b1;
      ardy_q     <= 1'b1;
      rd_phase_q <= 2'd0;
      rd_addr_q  <= {EMIF_ADDR_W{1'b0}};
      rdata_q    <= {DATA_W{1'b0}};
    end else begin
      are_q      <= emif.are;
      awe_q      <= emif.awe;
      ardy_q     <= ardy_d;
      rd_phase_q <= rd_phase_d;
      rd_addr_q  <= rd_addr_d;
      rdata_q    <= rdata_d;
    end
  end

  // Reset releases the shared EMIF lines immediately, without waiting for a clock
  assign ardy     = (sel_s && rst_n) ? ardy_q : 1'bz;
  assign data_bus = (sel_s && !emif.are && rst_n) ? rdata_q : {DATA_W{1'bz}};

  assign emif_unused_s = ^{emif.addr, emif.bank_select, data_bus};

endmodule

// File: tb/tb_capture_ram_bank.sv
// Self-checking bench for capture_ram_bank: table-driven EMIF reads through a
// scoreboard queue plus hand-written sequences for handshake, wrap and reset cases.
module tb_capture_ram_bank;
  import capture_pkg::*;

  localparam int DW = 16, AW = 6, NC = 2, PRE = 8, POST = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, sample_valid, trigger, done, tb_drv;
  logic [NC*DW-1:0]  sample_in;
  logic [DW-1:0]     tb_wdata;
  tri1  [DW-1:0]     data_bus;
  tri0               ardy;

  assign data_bus = tb_drv ? tb_wdata : {DW{1'bz}};

  capture_ram_bank_if emif ();

  capture_ram_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_CH(NC), .BANK_BIT(3), .PRE_LEN(PRE), .POST_LEN(POST)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .trigger(trigger), .emif(emif), .data_bus(data_bus), .ardy(ardy), .done(done)
  );

  typedef struct {
    string       name;
    logic [18:0] addr;
    logic [15:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_q[$];
  string       nm_q[$];
  vec_t        tbl[$];

  function automatic logic [18:0] sa(input int ch, input int i);
    return 19'((ch << AW) | i);
  endfunction

  function automatic logic [18:0] ra(input logic [1:0] off);
    logic [18:0] a;
    a = 19'h40000;
    a[1:0] = off;
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic reg_write(input logic [1:0] off, input logic [15:0] val, input logic trig);
    emif.addr = ra(off);
    tb_wdata = val;
    tb_drv = 1'b1;
    emif.bank_select = 4'b0111;
    emif.awe = 1'b0;
    trigger = trig;
    tick();
    trigger = 1'b0;
    emif.awe = 1'b1;
    tick();
    tb_drv = 1'b0;
    emif.bank_select = 4'b1111;
  endtask

  task automatic send(input int n, input logic trig);
    sample_in = {16'(16'h0100 + n), 16'(n)};
    sample_valid = 1'b1;
    trigger = trig;
    tick();
    sample_valid = 1'b0;
    trigger = 1'b0;
  endtask

  task automatic run(input int from, input int to, input int trig_at);
    for (int n = from; n <= to; n++) send(n, n == trig_at);
  endtask

  // Expected value queued at issue, popped when ardy reports the data valid
  task automatic sb_read(input string nm, input logic [18:0] a, input logic [15:0] exp);
    logic got;
    exp_q.push_back(exp);
    nm_q.push_back(nm);
    emif.addr = a;
    emif.bank_select = 4'b0111;
    emif.are = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      tick();
      if (ardy === 1'b1) got = 1'b1;
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: ardy never rose, got %b expected 1", nm_q.pop_front(), ardy);
      void'(exp_q.pop_front());
    end else begin
      check(nm_q.pop_front(), 32'(data_bus), 32'(exp_q.pop_front()));
    end
    emif.are = 1'b1;
    tick();
    emif.bank_select = 4'b1111;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; trigger = 1'b0;
    tb_drv = 1'b0; tb_wdata = 16'h0000;
    emif.addr = 19'h0; emif.bank_select = 4'b1111; emif.are = 1'b1; emif.awe = 1'b1;

    tbl.push_back('{"s1_ch0_i0",   sa(0, 0),      16'd12});
    tbl.push_back('{"s1_ch0_i5",   sa(0, 5),      16'd17});
    tbl.push_back('{"s1_ch0_i23",  sa(0, 23),     16'd35});
    tbl.push_back('{"s1_ch1_i0",   sa(1, 0),      16'h010C});
    tbl.push_back('{"s1_ch1_i23",  sa(1, 23),     16'h0123});
    tbl.push_back('{"s1_status",   ra(REG_STATUS), 16'h0004});
    tbl.push_back('{"s1_trig_ptr", ra(REG_TRIG),  16'd20});
    tbl.push_back('{"s1_wr_ptr",   ra(REG_WRPTR), 16'd36});
    tbl.push_back('{"s1_ctrl",     ra(REG_CTRL),  16'h0000});

    // Reset state
    do_reset();
    check("rst_done", 32'(done), 32'd0);
    check("rst_ardy_unselected_z", 32'(ardy), 32'd0);
    emif.bank_select = 4'b0111;
    #1;
    check("ardy_idle_selected", 32'(ardy), 32'd1);
    check("data_z_are_high", 32'(data_bus), 32'hFFFF);
    emif.bank_select = 4'b1111;
    sb_read("rst_status", ra(REG_STATUS), 16'h0000);
    sb_read("rst_trig_ptr", ra(REG_TRIG), 16'h0000);
    sb_read("rst_wr_ptr", ra(REG_WRPTR), 16'h0000);

    // Basic capture, trigger at n=20
    reg_write(REG_CTRL, 16'h0001, 1'b0);
    sb_read("s1_status_pre", ra(REG_STATUS), 16'h0001);
    run(0, 34, 20);
    check("s1_done_before_last", 32'(done), 32'd0);
    send(35, 1'b0);
    check("s1_done_after_last", 32'(done), 32'd1);
    foreach (tbl[k]) sb_read(tbl[k].name, tbl[k].addr, tbl[k].exp);

    // Read handshake timing and deselected tri-state
    emif.addr = ra(REG_TRIG);
    emif.bank_select = 4'b0111;
    emif.are = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("hs_ardy_cycle%0d", c), 32'(ardy), (c == 3) ? 32'd1 : 32'd0);
    end
    check("hs_data", 32'(data_bus), 32'd20);
    emif.bank_select = 4'b1111;
    #1;
    check("hs_data_z_deselected", 32'(data_bus), 32'hFFFF);
    check("hs_ardy_z_deselected", 32'(ardy), 32'd0);
    emif.are = 1'b1;
    tick();

    // Early trigger ignored in PRE, later trigger captures 22..45
    reg_write(REG_CTRL, 16'h0001, 1'b0);
    check("s2_done_cleared", 32'(done), 32'd0);
    run(0, 3, 3);
    sb_read("s2_status_early", ra(REG_STATUS), 16'h0009);
    run(4, 44, 30);
    check("s2_done_before_last", 32'(done), 32'd0);
    send(45, 1'b0);
    check("s2_done_after_last", 32'(done), 32'd1);
    sb_read("s2_ch0_i0", sa(0, 0), 16'd22);
    sb_read("s2_ch0_i23", sa(0, 23), 16'd45);
    sb_read("s2_ch1_i10", sa(1, 10), 16'h0120);
    sb_read("s2_trig_ptr", ra(REG_TRIG), 16'd2);
    sb_read("s2_status_done", ra(REG_STATUS), 16'h000C);

    // Ring wrap: 100 samples before the trigger
    do_reset();
    reg_write(REG_CTRL, 16'h0001, 1'b0);
    run(0, 114, 100);
    check("s3_done_before_last", 32'(done), 32'd0);
    send(115, 1'b0);
    check("s3_done_after_last", 32'(done), 32'd1);
    sb_read("s3_trig_ptr", ra(REG_TRIG), 16'd36);
    sb_read("s3_ch1_i0", sa(1, 0), 16'h015C);
    sb_read("s3_ch1_i23", sa(1, 23), 16'h0173);
    sb_read("s3_wr_ptr", ra(REG_WRPTR), 16'd52);

    // Arm and trigger in the same cycle while ARMED
    reg_write(REG_CTRL, 16'h0001, 1'b0);
    run(300, 309, -1);
    sb_read("s4_status_armed", ra(REG_STATUS), 16'h0002);
    reg_write(REG_CTRL, 16'h0001, 1'b1);
    sb_read("s4_status_rearmed", ra(REG_STATUS), 16'h0001);
    sb_read("s4_trig_ptr_kept", ra(REG_TRIG), 16'd36);
    check("s4_done", 32'(done), 32'd0);

    // Reset in POST: immediate release of ardy, capture aborted
    run(200, 207, -1);
    send(208, 1'b1);
    run(209, 211, -1);
    sb_read("s5_status_post", ra(REG_STATUS), 16'h0003);
    emif.bank_select = 4'b0111;
    #1;
    check("s5_ardy_before_reset", 32'(ardy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s5_ardy_z_in_reset", 32'(ardy), 32'd0);
    check("s5_done_in_reset", 32'(done), 32'd0);
    tick();
    tick();
    emif.bank_select = 4'b1111;
    rst_n = 1'b1;
    tick();
    run(16'h7000, 16'h7004, -1);
    sb_read("s5_status_idle", ra(REG_STATUS), 16'h0000);
    sb_read("s5_wr_ptr_idle", ra(REG_WRPTR), 16'h0000);
    sb_read("s5_row0_not_written", sa(0, 8), 16'd202);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
